// File: rtl/mul_writeback_unit.sv
// mul_writeback_unit: shift-add multiplier (one multiplier bit per clock) that writes its product to the register file.
// Build option MUL_HI_WRITE_EN: also write the upper product half to (RD+1) mod 2**IDX_W in a second writeback cycle.
`timescale 1ns/1ps
module mul_writeback_unit #(
  parameter int WIDTH = 24,
  parameter int IDX_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [IDX_W-1:0] RdIn,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [IDX_W-1:0] RD,
  output logic [WIDTH-1:0] WriteData,
  output logic             RegWrite
);

  localparam int CNT_W = $clog2(WIDTH);
`ifdef MUL_HI_WRITE_EN
  localparam int ACC_W = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, WB_LO = 2'd2, WB_HI = 2'd3} state_t;
`else
  // Only the low half is ever written, so the upper accumulator bits are not kept.
  localparam int ACC_W = WIDTH;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, WB_LO = 2'd2} state_t;
`endif

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] rd_q, rd_out;
  logic [WIDTH-1:0] wd_out;
  logic [ACC_W-1:0] acc, partial, acc_next;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  assign partial   = b_q[0] ? (ACC_W'(a_q) << cnt) : '0;
  assign acc_next  = acc + partial;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign RD        = rd_out;
  assign WriteData = wd_out;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state = state;
    Busy       = (state != IDLE);
    RegWrite   = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: if (Start) next_state = CALC;
      CALC: if (last_iter) next_state = WB_LO;
`ifdef MUL_HI_WRITE_EN
      WB_LO: begin
        RegWrite   = 1'b1;
        next_state = WB_HI;
      end
      WB_HI: begin
        RegWrite   = 1'b1;
        Done       = 1'b1;
        next_state = IDLE;
      end
`else
      WB_LO: begin
        RegWrite   = 1'b1;
        Done       = 1'b1;
        next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      rd_out <= '0;
      wd_out <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples pre-edge values.
      state <= next_state;
      case (state)
        IDLE: begin
          if (Start) begin
            a_q  <= OperandA;
            b_q  <= OperandB;
            rd_q <= RdIn;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        CALC: begin
          acc <= acc_next;
          b_q <= b_q >> 1;
          cnt <= cnt + 1'b1;
          // Write port registers load on the edge into WB_LO, so they hold steady through writeback.
          if (last_iter) begin
            rd_out <= rd_q;
            wd_out <= acc_next[WIDTH-1:0];
          end
        end
`ifdef MUL_HI_WRITE_EN
        WB_LO: begin
          rd_out <= rd_q + 1'b1;
          wd_out <= acc[ACC_W-1:WIDTH];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
